// File: rtl/connect6_pkg.sv
// Shared types and constants for the Connect6 engine front end.
// Used by the move-frame receiver and the stages downstream of it.
package connect6_pkg;

   localparam int         BOARD_N   = 19;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef logic [5:0] coord_t;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_COUNT   = 3'd1;
   localparam logic [2:0] ERR_RANGE   = 3'd2;
   localparam logic [2:0] ERR_DUP     = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;
   localparam logic [2:0] ERR_OVERRUN = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CNT, ST_X1, ST_Y1, ST_X2, ST_Y2, ST_CHECK, ST_HOLD
   } state_e;

   // Range test on the full received byte, so values such as 8'h40 cannot alias onto the board.
   function automatic logic in_range(input logic [7:0] b);
      return b < 8'(BOARD_N);
   endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: reloads on every received byte and counts down while a frame is open.
// The expire output is a single-cycle pulse after TIMEOUT_CYC consecutive idle cycles.
module byte_timeout #(
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic run,
   output logic expire
);

   localparam int             W        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [W-1:0]   LOAD_VAL = W'(TIMEOUT_CYC);

   logic [W-1:0] cnt_q, cnt_d;

   // NOTE: cnt_d gets its default first, so no path through this block can infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (load)                cnt_d = LOAD_VAL;
      else if (!run)           cnt_d = '0;
      else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
   end

   assign expire = run && !load && (cnt_q == W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/move_frame_rx.sv
// Parses the opponent's move frame from the host byte link and presents the validated
// stones with a valid/ack handshake; compute_move then requests our own move.
module move_frame_rx
   import connect6_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output coord_t     x_1,
   output coord_t     y_1,
   output coord_t     x_2,
   output coord_t     y_2,
   output logic [1:0] move_count,
   output logic       move_valid,
   input  logic       move_ack,
   output logic       compute_move,
   output logic       frame_err,
   output logic [2:0] err_code
);

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   coord_t     cap_x1_q, cap_y1_q, cap_x2_q, cap_y2_q;
   coord_t     cap_x1_d, cap_y1_d, cap_x2_d, cap_y2_d;
   logic       bad_q, bad_d;
   coord_t     x1_q, y1_q, x2_q, y2_q, x1_d, y1_d, x2_d, y2_d;
   logic [1:0] mc_q, mc_d;
   logic       valid_q, valid_d, compute_q, compute_d, err_q, err_d;
   logic [2:0] code_q, code_d;

   logic timed, expire, bad_byte;

   assign timed    = state_q inside {ST_CNT, ST_X1, ST_Y1, ST_X2, ST_Y2};
   assign bad_byte = !in_range(rx_data);

   byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (rx_valid),
      .run    (timed),
      .expire (expire)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_x1_d  = cap_x1_q;
      cap_y1_d  = cap_y1_q;
      cap_x2_d  = cap_x2_q;
      cap_y2_d  = cap_y2_q;
      bad_d     = bad_q;
      x1_d      = x1_q;
      y1_d      = y1_q;
      x2_d      = x2_q;
      y2_d      = y2_q;
      mc_d      = mc_q;
      valid_d   = valid_q;
      compute_d = compute_q;
      err_d     = 1'b0;
      code_d    = code_q;

      if (timed && expire) begin
         err_d   = 1'b1;
         code_d  = ERR_TIMEOUT;
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
               state_d   = ST_CNT;
               compute_d = 1'b0;
               bad_d     = 1'b0;
            end
            ST_CNT: if (rx_valid) begin
               if (rx_data == 8'd1 || rx_data == 8'd2) begin
                  cnt_d   = rx_data[1:0];
                  state_d = ST_X1;
               end else begin
                  err_d   = 1'b1;
                  code_d  = ERR_COUNT;
                  state_d = ST_IDLE;
               end
            end
            ST_X1: if (rx_valid) begin
               cap_x1_d = rx_data[5:0];
               bad_d    = bad_q | bad_byte;
               state_d  = ST_Y1;
            end
            ST_Y1: if (rx_valid) begin
               cap_y1_d = rx_data[5:0];
               bad_d    = bad_q | bad_byte;
               state_d  = (cnt_q == 2'd2) ? ST_X2 : ST_CHECK;
            end
            ST_X2: if (rx_valid) begin
               cap_x2_d = rx_data[5:0];
               bad_d    = bad_q | bad_byte;
               state_d  = ST_Y2;
            end
            ST_Y2: if (rx_valid) begin
               cap_y2_d = rx_data[5:0];
               bad_d    = bad_q | bad_byte;
               state_d  = ST_CHECK;
            end
            ST_CHECK: begin
               // A byte landing here is dropped; the frame verdict below still wins err_code.
               if (rx_valid) begin
                  err_d  = 1'b1;
                  code_d = ERR_OVERRUN;
               end
               if (bad_q) begin
                  err_d   = 1'b1;
                  code_d  = ERR_RANGE;
                  state_d = ST_IDLE;
               end else if (cnt_q == 2'd2 && cap_x1_q == cap_x2_q && cap_y1_q == cap_y2_q) begin
                  err_d   = 1'b1;
                  code_d  = ERR_DUP;
                  state_d = ST_IDLE;
               end else begin
                  x1_d    = cap_x1_q;
                  y1_d    = cap_y1_q;
                  x2_d    = (cnt_q == 2'd2) ? cap_x2_q : cap_x1_q;
                  y2_d    = (cnt_q == 2'd2) ? cap_y2_q : cap_y1_q;
                  mc_d    = cnt_q;
                  valid_d = 1'b1;
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (rx_valid) begin
                  err_d  = 1'b1;
                  code_d = ERR_OVERRUN;
               end
               if (move_ack) begin
                  valid_d   = 1'b0;
                  compute_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         cap_x1_q  <= '0;
         cap_y1_q  <= '0;
         cap_x2_q  <= '0;
         cap_y2_q  <= '0;
         bad_q     <= 1'b0;
         x1_q      <= '0;
         y1_q      <= '0;
         x2_q      <= '0;
         y2_q      <= '0;
         mc_q      <= '0;
         valid_q   <= 1'b0;
         compute_q <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cap_x1_q  <= cap_x1_d;
         cap_y1_q  <= cap_y1_d;
         cap_x2_q  <= cap_x2_d;
         cap_y2_q  <= cap_y2_d;
         bad_q     <= bad_d;
         x1_q      <= x1_d;
         y1_q      <= y1_d;
         x2_q      <= x2_d;
         y2_q      <= y2_d;
         mc_q      <= mc_d;
         valid_q   <= valid_d;
         compute_q <= compute_d;
         err_q     <= err_d;
         code_q    <= code_d;
      end
   end

   assign x_1          = x1_q;
   assign y_1          = y1_q;
   assign x_2          = x2_q;
   assign y_2          = y2_q;
   assign move_count   = mc_q;
   assign move_valid   = valid_q;
   assign compute_move = compute_q;
   assign frame_err    = err_q;
   assign err_code     = code_q;

endmodule

// File: tb/tb_move_frame_rx.sv
// Bench for move_frame_rx: directed frames plus randomized frames, each judged by a
// frame-level model that decides accept/reject from the frame contents alone.
module tb_move_frame_rx;
   import connect6_pkg::*;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   coord_t     x_1, y_1, x_2, y_2;
   logic [1:0] move_count;
   logic       move_valid;
   logic       move_ack;
   logic       compute_move;
   logic       frame_err;
   logic [2:0] err_code;

   int checks   = 0;
   int failures = 0;

   int ex1, ey1, ex2, ey2, ecnt, exp_code;
   bit exp_compute;

   move_frame_rx #(.TIMEOUT_CYC(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .x_1          (x_1),
      .y_1          (y_1),
      .x_2          (x_2),
      .y_2          (y_2),
      .move_count   (move_count),
      .move_valid   (move_valid),
      .move_ack     (move_ack),
      .compute_move (compute_move),
      .frame_err    (frame_err),
      .err_code     (err_code)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
      end
   endtask

   task automatic check_outs(input string tag);
      check({tag, "_x1"},      32'(x_1),          32'(ex1));
      check({tag, "_y1"},      32'(y_1),          32'(ey1));
      check({tag, "_x2"},      32'(x_2),          32'(ex2));
      check({tag, "_y2"},      32'(y_2),          32'(ey2));
      check({tag, "_count"},   32'(move_count),   32'(ecnt));
      check({tag, "_compute"}, 32'(compute_move), 32'(exp_compute));
      check({tag, "_code"},    32'(err_code),     32'(exp_code));
   endtask

   // Drive at a falling edge; the byte is consumed on the next rising edge and the task
   // returns at the following falling edge, where the result of that edge is visible.
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      ex1 = 0; ey1 = 0; ex2 = 0; ey2 = 0; ecnt = 0;
      exp_code = 0; exp_compute = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] cnt_b, input logic [7:0] c [4],
                            input int ack_delay, input bit hold_ov, input bit chk_ov);
      int n;
      int code;
      n = (cnt_b == 8'd1 || cnt_b == 8'd2) ? int'(cnt_b) : 0;
      code = 0;
      if (n == 0) code = 1;
      else begin
         for (int i = 0; i < 2 * n; i++) if (c[i] >= 8'd19) code = 2;
         if (code == 0 && n == 2 && c[0] == c[2] && c[1] == c[3]) code = 3;
      end

      check("pre_sync_compute", 32'(compute_move), 32'(exp_compute));
      send_byte(SYNC_BYTE);
      exp_compute = 1'b0;
      check("sync_compute", 32'(compute_move), 32'(exp_compute));
      idle($urandom_range(0, 3));
      send_byte(cnt_b);
      if (n == 0) begin
         check("cnt_err", 32'(frame_err), 32'd1);
         check("cnt_code", 32'(err_code), 32'd1);
         exp_code = 1;
         idle(1);
         check("cnt_err_pulse", 32'(frame_err), 32'd0);
         check("cnt_valid", 32'(move_valid), 32'd0);
         return;
      end
      for (int i = 0; i < 2 * n; i++) begin
         idle($urandom_range(0, 3));
         send_byte(c[i]);
      end
      check("capture_valid", 32'(move_valid), 32'd0);
      check("capture_err", 32'(frame_err), 32'd0);
      if (chk_ov) send_byte(8'h77);
      else        idle(1);
      check("verdict_err", 32'(frame_err), 32'((code != 0) || chk_ov));
      if (code != 0) begin
         exp_code = code;
         check("rej_valid", 32'(move_valid), 32'd0);
         check_outs("rej");
         idle(1);
         check("rej_pulse", 32'(frame_err), 32'd0);
         return;
      end
      if (chk_ov) exp_code = 5;
      ex1 = c[0]; ey1 = c[1];
      ex2 = (n == 2) ? c[2] : c[0];
      ey2 = (n == 2) ? c[3] : c[1];
      ecnt = n;
      check("hold_valid", 32'(move_valid), 32'd1);
      check_outs("hold");
      if (hold_ov) begin
         send_byte(8'h3C);
         exp_code = 5;
         check("ov_err", 32'(frame_err), 32'd1);
         check("ov_valid", 32'(move_valid), 32'd1);
         check_outs("ov");
         idle(1);
         check("ov_pulse", 32'(frame_err), 32'd0);
      end
      for (int k = 0; k < ack_delay; k++) begin
         idle(1);
         check("wait_valid", 32'(move_valid), 32'd1);
         check_outs("wait");
      end
      move_ack = 1'b1;
      idle(1);
      move_ack = 1'b0;
      exp_compute = 1'b1;
      check("ack_valid", 32'(move_valid), 32'd0);
      check_outs("ack");
   endtask

   initial begin
      logic [7:0] c [4];
      logic [7:0] cb;
      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; move_ack = 1'b0;
      model_reset();
      idle(2);
      check("rst_valid", 32'(move_valid), 32'd0);
      check("rst_err", 32'(frame_err), 32'd0);
      check_outs("rst");
      rst_n = 1'b1;
      idle(1);

      send_byte(8'h00);
      check("garbage0_err", 32'(frame_err), 32'd0);
      send_byte(8'hFF);
      check("garbage1_err", 32'(frame_err), 32'd0);

      run_frame(8'h02, '{8'h03, 8'h04, 8'h0A, 8'h0B}, 5, 1'b0, 1'b0);
      move_ack = 1'b1;
      run_frame(8'h01, '{8'h09, 8'h09, 8'h00, 8'h00}, 0, 1'b0, 1'b0);
      run_frame(8'h02, '{8'h12, 8'h00, 8'h13, 8'h05}, 0, 1'b0, 1'b0);
      run_frame(8'h01, '{8'h12, 8'h12, 8'h00, 8'h00}, 2, 1'b0, 1'b0);
      run_frame(8'h02, '{8'h05, 8'h05, 8'h05, 8'h05}, 0, 1'b0, 1'b0);
      run_frame(8'h03, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b0, 1'b0);
      run_frame(8'h01, '{8'h40, 8'h02, 8'h00, 8'h00}, 0, 1'b0, 1'b0);
      run_frame(8'h02, '{8'h01, 8'h02, 8'h03, 8'h04}, 3, 1'b1, 1'b0);
      run_frame(8'h01, '{8'h07, 8'h08, 8'h00, 8'h00}, 1, 1'b0, 1'b1);

      // Silence after X1: the abort lands exactly TO edges after the last byte's edge.
      send_byte(SYNC_BYTE);
      exp_compute = 1'b0;
      send_byte(8'h02);
      send_byte(8'h01);
      for (int k = 1; k <= TO; k++) begin
         idle(1);
         if (k >= TO - 1) check("timeout_err", 32'(frame_err), 32'(k == TO));
      end
      exp_code = 4;
      check_outs("timeout");
      run_frame(8'h02, '{8'h00, 8'h12, 8'h12, 8'h00}, 0, 1'b0, 1'b0);

      for (int f = 0; f < 40; f++) begin
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            cb = 8'($urandom_range(0, 255));
            if (cb == SYNC_BYTE) cb = 8'h5A;
            send_byte(cb);
            check("rand_garbage_err", 32'(frame_err), 32'd0);
         end
         cb = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(3, 255)) :
              ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
         for (int i = 0; i < 4; i++) begin
            c[i] = 8'($urandom_range(0, 18));
            if ($urandom_range(0, 14) == 0) c[i] = 8'($urandom_range(19, 255));
         end
         if ($urandom_range(0, 5) == 0) begin
            c[2] = c[0];
            c[3] = c[1];
         end
         run_frame(cb, c, $urandom_range(0, 20), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0));
      end

      // Reset while waiting for Y2 after a frame left non-zero outputs.
      run_frame(8'h02, '{8'h0E, 8'h0F, 8'h10, 8'h11}, 0, 1'b0, 1'b0);
      send_byte(SYNC_BYTE);
      send_byte(8'h02);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      model_reset();
      check("rst2_valid", 32'(move_valid), 32'd0);
      check("rst2_err", 32'(frame_err), 32'd0);
      check_outs("rst2");
      run_frame(8'h01, '{8'h06, 8'h0C, 8'h00, 8'h00}, 1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
